button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Conditions the four raw active-low KEY pushbuttons (player 1 left/right, player 2 left/right) before they reach the processor's turn inputs.
- Per button: 2-flop synchronizer, stable-time debounce, one-cycle press pulse and a sticky pending flag.
- The sticky flag holds each press until the game loop, running on its slow tick, acknowledges it, so no turn is lost between game steps.
- Sits between the board KEY pins and the processor's but_left1/but_right1/but_left2/but_right2 inputs.

Parameters:
- NUM_BTN, 4: number of button channels. Bit 3 = P1 left, 2 = P1 right, 1 = P2 left, 0 = P2 right.
- DEBOUNCE_CYCLES, 250000: consecutive stable clock cycles required to accept a new level (5 ms at 50 MHz). Minimum 2.
- CNT_W, 18: debounce counter width. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clock, in, 1: single clock; all state on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- key_n, in, NUM_BTN: raw pushbutton pins, active low, asynchronous to clock.
- pending_ack, in, NUM_BTN: per-bit clear of btn_pending; sampled each rising edge.
- btn_level, out, NUM_BTN: debounced level, 1 = held.
- btn_press, out, NUM_BTN: one-cycle pulse on each debounced press.
- btn_pending, out, NUM_BTN: sticky press flag, cleared only by pending_ack or reset.

Behaviour:
- Reset (async assert, released synchronously by the upstream Reset_Delay path):
  - synchronizer flops = 1 (released)
  - counters = 0
  - btn_level = 0, btn_press = 0, btn_pending = 0
- Synchronizer: sample = second flop of ~... chain on key_n; active-high sample s = ~sync2. Two cycles from pin change to s.
- Debounce, per channel:
  - s == btn_level: counter <= 0.
  - s != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level <= s, counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any glitch shorter than DEBOUNCE_CYCLES consecutive cycles leaves btn_level unchanged and restarts the count.
- Latency: a clean pin transition at edge k gives btn_level change at edge k+2+DEBOUNCE_CYCLES (±1 for async sampling). Release uses the same timing.
- btn_press: registered.
  - Asserted for exactly one cycle, the same cycle btn_level first reads 1 after a 0->1 change.
  - Never asserted on release. Never asserted twice without an intervening debounced release.
- btn_pending, per bit:
  - Next value = btn_press_next | (btn_pending & ~pending_ack).
  - A press arriving in the same cycle as its ack wins: bit stays 1.
  - Ack with bit already 0: no effect.
  - A second press while pending stays 1; there is no count and no overflow.
- Channels are independent. Simultaneous presses on all bits set all pending bits in the same cycle. Left and right of the same player may both be pending; arbitration is the processor's job.
- Reset mid-count: counter and level clear immediately. A button still held after reset release is re-debounced and produces one press.
- No combinational path from any input to any output.

Decomposition:
- Shared package button_pkg:
  - BTN_P1_LEFT=3, BTN_P1_RIGHT=2, BTN_P2_LEFT=1, BTN_P2_RIGHT=0
  - default DEBOUNCE_CYCLES
  - DEBOUNCE_SIM=4 for benches
- Sub-module button_debounce_channel: one bit of synchronizer, counter, level and press logic, parameterised by DEBOUNCE_CYCLES/CNT_W.
- Top generate-instantiates NUM_BTN channels and holds the btn_pending register.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle, key_n=4'b1111 for 50 cycles -> btn_level=0, btn_press=0, btn_pending=0 throughout.
- key_n[3] driven low at edge 10 and held -> btn_level[3]=1 and btn_press[3]=1 at edge 16 only. btn_pending[3]=1 from edge 16 until pending_ack[3] pulsed at edge 30, then 0 at edge 31.
- key_n[2] bounce: low 2 cycles, high 1, low 3, high 1, then low steady -> exactly one btn_press[2] pulse, 6 cycles after the steady low reaches the pins. No pulse during the bounce.
- Press pulse on bit 0 coincident with pending_ack[0]=1 -> btn_pending[0]=1 after the edge. Ack on bit 1 with pending[1]=0 -> stays 0.
- All four key_n low at the same edge -> btn_press=4'b1111 in a single cycle, btn_pending=4'b1111. Release all -> btn_level=0 after 6 cycles, no press pulse.
- key_n[1] held low, reset asserted mid-count for 3 cycles -> outputs 0 during reset. After release, one btn_press[1] at release+6.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg
//   Shared constants for the pushbutton conditioner: the bit position of
//   each player button in the NUM_BTN-wide vectors, and the debounce
//   lengths used on hardware (5 ms at 50 MHz) and in simulation benches.
package button_pkg;

    // Bit positions of the board buttons in key_n / btn_* vectors.
    localparam int BTN_P1_LEFT  = 3;
    localparam int BTN_P1_RIGHT = 2;
    localparam int BTN_P2_LEFT  = 1;
    localparam int BTN_P2_RIGHT = 0;

    localparam int NUM_BTN_DEFAULT = 4;

    // 250000 cycles = 5 ms at 50 MHz; 18 bits covers it (2^18 = 262144).
    localparam int DEBOUNCE_CYCLES = 250000;
    localparam int CNT_W_DEFAULT   = 18;

    // Short debounce for simulation so a press resolves in a handful of cycles.
    localparam int DEBOUNCE_SIM = 4;

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Groups the button-side and game-side signals of the conditioner.
//   master : board/game side - drives key_n and pending_ack, reads results.
//   slave  : conditioner     - reads key_n and pending_ack, drives results.
//   Signals:
//     key_n       raw active-low pushbutton pins (asynchronous)
//     pending_ack per-bit clear of btn_pending
//     btn_level   debounced level, 1 = held
//     btn_press   one-cycle pulse per debounced press
//     btn_pending sticky press flag
interface button_conditioner_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] key_n;
    logic [NUM_BTN-1:0] pending_ack;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_pending;

    modport master (
        output key_n,
        output pending_ack,
        input  btn_level,
        input  btn_press,
        input  btn_pending
    );

    modport slave (
        input  key_n,
        input  pending_ack,
        output btn_level,
        output btn_press,
        output btn_pending
    );
endinterface

// File: rtl/button_debounce_channel.sv
// button_debounce_channel
//   One button: 2-flop synchronizer on the raw active-low pin, stable-time
//   debounce counter, registered debounced level and registered press pulse.
//   Ports:
//     clock, reset     clock and asynchronous active-high reset
//     key_n            raw active-low pin
//     btn_level        debounced level (registered), 1 = held
//     btn_press        one-cycle press pulse (registered)
//     btn_press_next   next-state value of btn_press, for the pending register
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = button_pkg::DEBOUNCE_CYCLES,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_press_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             sample;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        sample  = ~sync2_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sample == level_q) begin
            // Input agrees with the accepted level: any partial count is a glitch.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // DEBOUNCE_CYCLES consecutive disagreeing samples: accept new level.
            level_d = sample;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Synchronizer resets to the released (high) pin value.
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign btn_level      = level_q;
    assign btn_press      = press_q;
    assign btn_press_next = press_d;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions the four active-low KEY pushbuttons for the game processor.
//   Each channel is synchronized and debounced; a debounced press sets a
//   sticky pending bit that the game loop clears with pending_ack on its
//   slow tick, so no press is lost between game steps.
//   Ports:
//     clock, reset  clock and asynchronous active-high reset
//     bus (slave)   key_n, pending_ack in; btn_level, btn_press, btn_pending out
//   All outputs are registered.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = button_pkg::DEBOUNCE_CYCLES,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    button_conditioner_if.slave   bus
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] press_next;
    logic [NUM_BTN-1:0] pending_q, pending_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clock          (clock),
            .reset          (reset),
            .key_n          (bus.key_n[i]),
            .btn_level      (level[i]),
            .btn_press      (press[i]),
            .btn_press_next (press_next[i])
        );
    end

    // A press landing in the same cycle as its ack keeps the bit set.
    always_comb begin
        pending_d = press_next | (pending_q & ~bus.pending_ack);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_pending = pending_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
    import button_pkg::*;

    localparam int N  = 4;
    localparam int DC = DEBOUNCE_SIM;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] pending;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    button_conditioner_if #(.NUM_BTN(N)) bus ();

    button_conditioner #(
        .NUM_BTN         (N),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_step = 0;
    int   press2_cnt = 0;
    exp_t exp_q[$];

    // Reference model: pins reach the sample two edges later; a channel's
    // level flips once the last DC samples all disagree with it.
    logic [N-1:0] m_pin_new, m_pin_old;
    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_level, m_pending;

    function automatic void model_reset();
        m_pin_new = '1;
        m_pin_old = '1;
        m_hist    = {};
        for (int i = 0; i < DC; i++) m_hist.push_back('0);
        m_level   = '0;
        m_pending = '0;
    endfunction

    function automatic exp_t model_edge(input logic [N-1:0] key, input logic [N-1:0] ack);
        logic [N-1:0] s;
        logic [N-1:0] press;
        exp_t e;
        s = ~m_pin_old;
        m_pin_old = m_pin_new;
        m_pin_new = key;
        m_hist.push_back(s);
        if (m_hist.size() > DC) void'(m_hist.pop_front());
        press = '0;
        for (int b = 0; b < N; b++) begin
            bit all_diff;
            all_diff = 1'b1;
            foreach (m_hist[j]) if (m_hist[j][b] == m_level[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[b] = ~m_level[b];
                press[b]   = m_level[b];
            end
        end
        m_pending = press | (m_pending & ~ack);
        e.level   = m_level;
        e.press   = press;
        e.pending = m_pending;
        return e;
    endfunction

    // Stimulus: inputs change at the falling edge, the expectation for the
    // following rising edge is queued at the same time.
    task automatic step(input logic [N-1:0] key, input logic [N-1:0] ack, input logic rst_v);
        exp_t e;
        @(negedge clock);
        reset           = rst_v;
        bus.key_n       = key;
        bus.pending_ack = ack;
        if (rst_v) begin
            model_reset();
            e = '0;
        end else begin
            e = model_edge(key, ack);
        end
        exp_q.push_back(e);
        n_step++;
    endtask

    task automatic hold(input logic [N-1:0] key, input int cycles);
        for (int i = 0; i < cycles; i++) step(key, '0, 1'b0);
    endtask

    // Monitor: one expectation per rising edge, checked 1 time unit later.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.btn_level !== e.level) begin
                n_fail++;
                $display("FAIL btn_level step %0d: got %b want %b", n_step, bus.btn_level, e.level);
            end
            n_cmp++;
            if (bus.btn_press !== e.press) begin
                n_fail++;
                $display("FAIL btn_press step %0d: got %b want %b", n_step, bus.btn_press, e.press);
            end
            n_cmp++;
            if (bus.btn_pending !== e.pending) begin
                n_fail++;
                $display("FAIL btn_pending step %0d: got %b want %b", n_step, bus.btn_pending, e.pending);
            end
            if (bus.btn_press[2] === 1'b1) press2_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] cur;
        int           hold_cnt[N];

        bus.key_n       = '1;
        bus.pending_ack = '0;
        model_reset();

        // Reset, then idle.
        for (int i = 0; i < 3; i++) step('1, '0, 1'b1);
        hold(4'b1111, 50);

        // P1 left held, ack while pending, then release.
        hold(4'b0111, 20);
        step(4'b0111, 4'b1000, 1'b0);
        hold(4'b0111, 3);
        hold(4'b1111, 10);

        // Bounce on P1 right: exactly one press.
        press2_cnt = 0;
        hold(4'b1011, 2);
        hold(4'b1111, 1);
        hold(4'b1011, 3);
        hold(4'b1111, 1);
        hold(4'b1011, 12);
        hold(4'b1111, 12);
        n_cmp++;
        if (press2_cnt != 1) begin
            n_fail++;
            $display("FAIL bounce_press_count: got %0d want 1", press2_cnt);
        end

        // P2 right press lands on the same edge as its ack; ack bit1 while clear.
        hold(4'b1110, 5);
        step(4'b1110, 4'b0011, 1'b0);
        hold(4'b1110, 4);
        hold(4'b1111, 10);
        step(4'b1111, 4'b0001, 1'b0);

        // All four together, ack all, release all.
        hold(4'b0000, 10);
        step(4'b0000, 4'b1111, 1'b0);
        hold(4'b1111, 10);

        // Reset mid-count with P2 left held.
        hold(4'b1101, 2);
        for (int i = 0; i < 3; i++) step(4'b1101, '0, 1'b1);
        hold(4'b1101, 10);
        hold(4'b1111, 10);

        // Randomized: per-bit random hold lengths, random acks, rare resets.
        cur = '1;
        for (int b = 0; b < N; b++) hold_cnt[b] = 0;
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] ack;
            for (int b = 0; b < N; b++) begin
                if (hold_cnt[b] == 0) begin
                    cur[b]      = 1'($urandom_range(0, 1));
                    hold_cnt[b] = $urandom_range(1, 9);
                end
                hold_cnt[b]--;
            end
            ack = N'($urandom & $urandom);
            step(cur, ack, ($urandom_range(0, 199) == 0));
        end

        // Drain the scoreboard.
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
